// File: rtl/demux_1to8_deser_if.sv
// Bus bundle for the 1-to-8 serial deserializer.
//
// Handshake: valid-only, no backpressure. The sink samples ser_in on every
// rising clk edge where in_valid is high; out_valid is a one-cycle strobe that
// marks y (and parity_err) as carrying a freshly completed frame. There is no
// ready signal, so the consumer must capture y before the next frame lands.
//
// fsm_state is a debug view of the deserializer FSM (0 = COLLECT, 1 = PARITY).
interface demux_1to8_deser_if;
    logic       ser_in;
    logic       in_valid;
    logic       sync;
    logic [7:0] y;
    logic       out_valid;
    logic [2:0] bit_idx;
    logic       parity_err;
    logic       fsm_state;

    // Serial source / word consumer side.
    modport master (
        output ser_in, in_valid, sync,
        input  y, out_valid, bit_idx, parity_err, fsm_state
    );

    // Deserializer side.
    modport slave (
        input  ser_in, in_valid, sync,
        output y, out_valid, bit_idx, parity_err, fsm_state
    );
endinterface

// File: rtl/demux_1to8_deser.sv
// demux_1to8_deser: serial-to-parallel 1-to-8 deserializer.
// Bit i of a frame (LSB first) lands on y[i], matching mux select code i of
// the serializer on the transmit side. Completed frames are presented on a
// held y register with a one-cycle out_valid strobe.
//
// Optional feature macro: DEMUX_1TO8_PARITY_EN
//   defined   -> 9-bit frames: 8 data bits + even-parity bit, parity_err live
//   undefined -> 8-bit frames, parity_err tied to 0
module demux_1to8_deser (
    input  logic               clk,
    input  logic               rst_n,
    demux_1to8_deser_if.slave  bus
);

    typedef enum logic {
        COLLECT = 1'b0,
        PARITY  = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] sh_q, sh_d;        // shadow register collecting data bits
    logic [2:0] idx_q, idx_d;      // position the next valid bit goes to
    logic [7:0] y_q, y_d;          // held output word
    logic       ov_q, ov_d;        // frame-complete strobe

`ifdef DEMUX_1TO8_PARITY_EN
    logic       pe_q, pe_d;        // parity error of the last delivered frame
`endif

    // State and datapath registers, all cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= COLLECT;
            sh_q    <= 8'h00;
            idx_q   <= 3'd0;
            y_q     <= 8'h00;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            idx_q   <= idx_d;
            y_q     <= y_d;
            ov_q    <= ov_d;
        end
    end

`ifdef DEMUX_1TO8_PARITY_EN
    // Parity flag register, held until the next delivered frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pe_q <= 1'b0;
        end else begin
            pe_q <= pe_d;
        end
    end
`endif

    // Next-state and datapath logic; sync takes priority over everything.
    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        idx_d   = idx_q;
        y_d     = y_q;
        ov_d    = 1'b0;
`ifdef DEMUX_1TO8_PARITY_EN
        pe_d    = pe_q;
`endif

        if (bus.sync) begin
            // Drop the partial frame; a bit arriving with sync is bit 0.
            // Stale sh bits are harmless: a completed frame rewrites all 8.
            state_d = COLLECT;
            if (bus.in_valid) begin
                sh_d[0] = bus.ser_in;
                idx_d   = 3'd1;
            end else begin
                idx_d   = 3'd0;
            end
        end else if (bus.in_valid) begin
            case (state_q)
                COLLECT: begin
                    sh_d[idx_q] = bus.ser_in;
                    idx_d       = idx_q + 3'd1;   // wraps 7 -> 0
                    if (idx_q == 3'd7) begin
`ifdef DEMUX_1TO8_PARITY_EN
                        state_d = PARITY;
`else
                        y_d  = sh_d;              // includes bit 7 just written
                        ov_d = 1'b1;
`endif
                    end
                end
`ifdef DEMUX_1TO8_PARITY_EN
                PARITY: begin
                    // Parity bit is not stored; frame is delivered regardless.
                    y_d     = sh_q;
                    ov_d    = 1'b1;
                    pe_d    = (^sh_q) ^ bus.ser_in;
                    idx_d   = 3'd0;
                    state_d = COLLECT;
                end
`endif
                default: begin
                    state_d = COLLECT;
                    idx_d   = 3'd0;
                end
            endcase
        end
    end

    assign bus.y         = y_q;
    assign bus.out_valid = ov_q;
    assign bus.bit_idx   = idx_q;
    assign bus.fsm_state = state_q;
`ifdef DEMUX_1TO8_PARITY_EN
    assign bus.parity_err = pe_q;
`else
    assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_demux_1to8_deser.sv
// Testbench for demux_1to8_deser. Works in both the default and the
// DEMUX_1TO8_PARITY_EN build (frame length follows the macro).
module tb_demux_1to8_deser;

`ifdef DEMUX_1TO8_PARITY_EN
    localparam int FL = 9;
`else
    localparam int FL = 8;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    demux_1to8_deser_if bus ();

    demux_1to8_deser dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- checking ----------------
    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // ---------------- scoreboard ----------------
    // Entry = {parity_err, y}
    logic [8:0] exp_q[$];
    logic       per_en  = 1'b0;
    int         ref_cyc = 0;

    // Every out_valid strobe must match the oldest expected frame.
    always @(negedge clk) begin
        if (bus.out_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_ov", 1, 0);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                check("y", bus.y, e[7:0]);
                check("parity_err", bus.parity_err, e[8]);
            end
            if (per_en) begin
                check("frame_period", cyc - ref_cyc, FL);
                ref_cyc = cyc;
            end
        end
    end

    // ---------------- drivers ----------------
    // All drivers start and end at posedge+1.
    task automatic drive_bit(input logic b, input logic s);
        bus.ser_in   = b;
        bus.in_valid = 1'b1;
        bus.sync     = s;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.sync     = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        bus.sync     = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    // Drives the first n data bits of d without completing a frame.
    task automatic partial(input logic [7:0] d, input int n);
        for (int i = 0; i < n; i++) drive_bit(d[i], 1'b0);
    endtask

    task automatic send_frame(input logic [7:0] d, input int max_gap, input logic sync_first,
                              input logic bad_par, input logic hold_en, input logic [7:0] hold_y);
        logic pe;
`ifdef DEMUX_1TO8_PARITY_EN
        pe = bad_par;
`else
        pe = 1'b0;
        if (bad_par) $display("note: parity flip ignored in this build");
`endif
        exp_q.push_back({pe, d});
        for (int i = 0; i < 8; i++) begin
            drive_bit(d[i], sync_first && (i == 0));
            if (hold_en && i == 3) begin
                check("hold_y", bus.y, hold_y);
                check("hold_ov_low", bus.out_valid, 0);
            end
            if (max_gap > 0 && i < 7) idle($urandom_range(1, max_gap));
        end
`ifdef DEMUX_1TO8_PARITY_EN
        drive_bit((^d) ^ bad_par, 1'b0);
`endif
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    // ---------------- main sequence ----------------
    initial begin
        bus.ser_in   = 1'b0;
        bus.in_valid = 1'b0;
        bus.sync     = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_y", bus.y, 8'h00);
        check("rst_ov", bus.out_valid, 0);
        check("rst_idx", bus.bit_idx, 0);
        check("rst_pe", bus.parity_err, 0);
        rst_n = 1'b1;
        idle(2);

        // 0xA5, in_valid held high; latency from first drive is FL cycles
        ref_cyc = cyc;
        send_frame(8'hA5, 0, 1'b0, 1'b0, 1'b0, 8'h00);
        check("a5_latency", cyc - ref_cyc, FL);
        check("a5_ov", bus.out_valid, 1);
        check("a5_idx", bus.bit_idx, 0);
        idle(1);
        check("a5_ov_one_cycle", bus.out_valid, 0);
        check("a5_y_held", bus.y, 8'hA5);

        // 0x3C with gaps; y must hold 0xA5 mid-frame
        send_frame(8'h3C, 5, 1'b0, 1'b0, 1'b1, 8'hA5);
        idle(3);
        check("3c_y_held", bus.y, 8'h3C);

        // 5 bits of 0xFF, then sync with a valid bit 0 of 0x80
        partial(8'hFF, 5);
        check("pre_sync_idx", bus.bit_idx, 5);
        exp_q.push_back({1'b0, 8'h80});
        drive_bit(1'b0, 1'b1);
        check("sync_idx", bus.bit_idx, 1);
        for (int i = 1; i < 8; i++) drive_bit(1'b0 ^ (i == 7), 1'b0);
`ifdef DEMUX_1TO8_PARITY_EN
        drive_bit(1'b1, 1'b0);
`endif
        idle(2);

        // sync with in_valid low
        partial(8'hFF, 3);
        bus.sync = 1'b1;
        @(posedge clk); #1;
        bus.sync = 1'b0;
        check("sync_novalid_idx", bus.bit_idx, 0);
        check("sync_novalid_y", bus.y, 8'h80);
        send_frame(8'h96, 2, 1'b0, 1'b0, 1'b0, 8'h00);
        idle(2);

        // sync on the same edge as bit 7: sync wins
        partial(8'h00, 7);
        send_frame(8'hC3, 0, 1'b1, 1'b0, 1'b0, 8'h00);
        idle(2);

`ifdef DEMUX_1TO8_PARITY_EN
        // sync while waiting for the parity bit discards the frame
        partial(8'h11, 8);
        check("parity_state", bus.fsm_state, 1);
        send_frame(8'h2D, 0, 1'b1, 1'b0, 1'b0, 8'h00);
        idle(2);
`endif

        // Asynchronous reset mid-frame
        partial(8'hFF, 4);
        rst_n = 1'b0;
        #1;
        check("arst_y", bus.y, 8'h00);
        check("arst_ov", bus.out_valid, 0);
        check("arst_idx", bus.bit_idx, 0);
        check("arst_pe", bus.parity_err, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(1);
        send_frame(8'h5A, 0, 1'b0, 1'b0, 1'b0, 8'h00);
        idle(2);

        // Back-to-back frames, in_valid held high
        ref_cyc = cyc;
        per_en  = 1'b1;
        send_frame(8'h01, 0, 1'b0, 1'b0, 1'b0, 8'h00);
        send_frame(8'hFE, 0, 1'b0, 1'b0, 1'b0, 8'h00);
        send_frame(8'h77, 0, 1'b0, 1'b0, 1'b0, 8'h00);
        @(negedge clk); #1;
        per_en = 1'b0;
        @(posedge clk); #1;
        idle(2);

        // Random frames with random gaps
        for (int k = 0; k < 6; k++) begin
            send_frame(8'($urandom_range(0, 255)), $urandom_range(0, 3), 1'b0, 1'b0, 1'b0, 8'h00);
        end
        idle(2);

`ifdef DEMUX_1TO8_PARITY_EN
        // Parity good, then bad; bad frame still delivered and flag held
        send_frame(8'hA5, 0, 1'b0, 1'b0, 1'b0, 8'h00);
        send_frame(8'hA5, 0, 1'b0, 1'b1, 1'b0, 8'h00);
        idle(4);
        check("pe_held", bus.parity_err, 1);
        check("pe_y", bus.y, 8'hA5);
`endif

        idle(3);
        check("drain", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/demux_1to8_deser.md
# demux_1to8_deser

Sequential 1-to-8 demultiplexer (serial-to-parallel deserializer). It steers each valid serial input bit to the next of eight output positions, selected by an internal 3-bit index. It is the receive-side counterpart of the team's 8-to-1 mux used as a bit serializer: bit i of a frame lands on output i, the same mapping as mux select code i. Each completed frame is presented as a held 8-bit word with a one-cycle valid strobe.

## Interface
- No parameters; width is fixed at 8 outputs / 3-bit index.
- clk  input  1  rising-edge clock, single clock domain
- rst_n  input  1  reset, asynchronous assert, active-low
- ser_in  input  1  serial data bit
- in_valid  input  1  ser_in is sampled on this edge when high
- sync  input  1  frame restart; forces the current or next bit to index 0
- y  output  8  deserialized word; y[i] = bit i of the last completed frame
- out_valid  output  1  one-cycle strobe: y updated with a new frame
- bit_idx  output  3  index the next valid bit will be written to
- parity_err  output  1  parity mismatch on the frame flagged by out_valid (see Configuration)

## Operation
- Internal shadow register sh[7:0] collects bits. y is a separate hold register, stable between frames.
- Each edge with in_valid=1: sh[bit_idx] <= ser_in, then bit_idx <= bit_idx+1 (mod 8).
- Data phase ends when a bit is written at index 7:
  - Without the parity feature: on that same edge, y <= {ser_in, sh[6:0]}, out_valid <= 1 and bit_idx wraps to 0.
  - With the parity feature: see Configuration.
- States: COLLECT (data bits 0-7), plus PARITY when parity is enabled. Transitions:
  - COLLECT to PARITY on bit 7 (parity build only).
  - PARITY to COLLECT on the next valid bit.
  - Any state to COLLECT with index 0 on sync.
- in_valid=0: sh, bit_idx and state hold. Gaps of any length are allowed mid-frame.
- sync=1 discards the partial frame. y is not changed and out_valid does not fire.
  - If in_valid=1 in the same cycle, ser_in is written as bit 0 and bit_idx becomes 1.
  - If in_valid=0, bit_idx becomes 0.
- sync on the same edge as bit 7: sync wins, the frame is discarded and ser_in becomes bit 0.
- Unwritten sh bits from a discarded frame are never exposed. Every completed frame writes all 8 positions.

## Timing
- Reset values (asynchronous, immediate on rst_n low): y=8'h00, out_valid=0, bit_idx=0, parity_err=0, sh=0, state=COLLECT.
- Reset mid-frame discards the partial frame. The first valid bit after release is bit 0.
- Latency: y and out_valid change on the edge that samples the final bit of the frame. They are visible in the following cycle.
- out_valid is high for exactly one cycle per frame.
- Back-to-back frames with in_valid held high: out_valid every 8 cycles (9 with parity). There are no dead cycles between frames.
- bit_idx is registered and reflects the state after the most recent edge.
- No backpressure. The consumer must capture y before the next frame completes; y is simply overwritten.

## Configuration
- Macro: DEMUX_1TO8_PARITY_EN.
- Defined:
  - The frame is 9 valid bits: 8 data bits followed by one even-parity bit.
  - After bit 7 the block enters PARITY and bit_idx stays 0.
  - On the parity bit edge: y <= sh, out_valid <= 1 and parity_err <= (^sh) ^ ser_in.
  - parity_err is registered alongside out_valid, and is held until the next out_valid or reset.
  - A frame with bad parity is still delivered.
  - sync during PARITY discards the frame.
- Undefined:
  - 8-bit frames as described in Operation.
  - The PARITY state does not exist.
  - The parity_err port remains and is tied to 0.

## Test plan
- Reset then 0xA5 sent LSB-first (bits 1,0,1,0,0,1,0,1), in_valid held high -> y=8'hA5 and out_valid=1 for one cycle, 8 cycles after the first bit; bit_idx back to 0.
- 0x3C sent with in_valid=0 gaps of 1-5 cycles between bits -> y=8'h3C and a single out_valid. y keeps its previous value (0xA5) until then.
- Send 5 bits of 0xFF, then sync with in_valid=1 and ser_in=0, then 7 more bits of 0x80 -> one out_valid, y=8'h80; the partial frame never appears.
- rst_n pulsed low after 4 bits -> all outputs 0 immediately. The next 8 bits forming 0x5A give y=8'h5A.
- Back-to-back frames 0x01, 0xFE, 0x77 with in_valid held high -> out_valid at cycles 8, 16, 24 with those values in order.
- Build with DEMUX_1TO8_PARITY_EN:
  - 0xA5 followed by parity bit 0 -> out_valid with parity_err=0.
  - 0xA5 followed by parity bit 1 -> out_valid with parity_err=1 and y=8'hA5.
  - Frame period is 9 cycles.
